// File: rtl/spi_fread_dma.sv
// spi_fread_dma -- bus-mastering consumer for the SPI file-reader stream.
//
// Sends one read request (file id, offset, length), accepts the returned
// byte stream, packs it little-endian into 32-bit words and writes each word
// to memory as a Wishbone master. The last word of a transfer may be partial;
// its unfilled lanes are masked off and drive zero.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ctl_*             control: file id, offset, length (count-1), destination
//                     word address, start pulse, busy level, done pulse
//   req_*             read request towards the file reader (valid/ready)
//   resp_*            returned byte stream (valid/ready)
//   wb_*              Wishbone write master; wb_wmsk bit set = lane not written
module spi_fread_dma #(
  parameter int AW = 22,
  parameter int LW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   ctl_file_id,
  input  logic [31:0]   ctl_offset,
  input  logic [LW-1:0] ctl_len,
  input  logic [AW-1:0] ctl_dst_addr,
  input  logic          ctl_start,
  output logic          ctl_busy,
  output logic          ctl_done,
  output logic [31:0]   req_file_id,
  output logic [31:0]   req_offset,
  output logic [LW-1:0] req_len,
  output logic          req_valid,
  input  logic          req_ready,
  input  logic [7:0]    resp_data,
  input  logic          resp_valid,
  output logic          resp_ready,
  output logic [AW-1:0] wb_addr,
  output logic [31:0]   wb_wdata,
  output logic [3:0]    wb_wmsk,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic          wb_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   fid_q;
  logic [31:0]   off_q;
  logic [LW-1:0] len_q;
  logic [AW-1:0] dst_q;
  logic [LW:0]   remain;   // bytes still to be accepted; holds up to 2^LW
  logic [2:0]    lane;     // bytes packed into the current word, 0..4
  logic [31:0]   data;     // packing register, zeroed at every word start

  // NOTE: every register below is assigned with <= so all updates in this
  // block see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      fid_q  <= '0;
      off_q  <= '0;
      len_q  <= '0;
      dst_q  <= '0;
      remain <= '0;
      lane   <= '0;
      data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctl_start) begin
            fid_q  <= ctl_file_id;
            off_q  <= ctl_offset;
            len_q  <= ctl_len;
            dst_q  <= ctl_dst_addr;
            remain <= {1'b0, ctl_len} + 1'b1;
            lane   <= '0;
            data   <= '0;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_ready) state <= S_FILL;
        end
        S_FILL: begin
          if (resp_valid) begin
            data[{lane[1:0], 3'b000} +: 8] <= resp_data;
            lane   <= lane + 3'd1;
            remain <= remain - 1'b1;
            // Word is full, or this was the final byte of the transfer.
            if (lane == 3'd3 || remain == (LW+1)'(1)) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wb_ack) begin
            dst_q <= dst_q + 1'b1;
            lane  <= '0;
            data  <= '0;
            state <= (remain == '0) ? S_DONE : S_FILL;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs are decoded from registered state; only resp_ready follows
  // resp_valid directly so one byte can be taken in every valid cycle.
  assign ctl_busy    = (state != S_IDLE);
  assign ctl_done    = (state == S_DONE);
  assign req_valid   = (state == S_REQ);
  assign req_file_id = fid_q;
  assign req_offset  = off_q;
  assign req_len     = len_q;
  assign resp_ready  = (state == S_FILL) && resp_valid;
  assign wb_cyc      = (state == S_WRITE);
  assign wb_we       = wb_cyc;
  assign wb_addr     = dst_q;
  assign wb_wdata    = wb_cyc ? data : '0;

  // NOTE: wb_wmsk gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wb_wmsk = 4'hF;
    if (wb_cyc) begin
      case (lane)
        3'd1:    wb_wmsk = 4'b1110;
        3'd2:    wb_wmsk = 4'b1100;
        3'd3:    wb_wmsk = 4'b1000;
        3'd4:    wb_wmsk = 4'b0000;
        default: wb_wmsk = 4'hF;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_fread_dma.sv
// Scoreboard bench for spi_fread_dma: a byte-level reference model turns each
// transfer into the expected request and word writes; monitors compare what
// the DUT presents against those queues.
module tb_spi_fread_dma;
  localparam int AW = 22;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   ctl_file_id = '0;
  logic [31:0]   ctl_offset = '0;
  logic [LW-1:0] ctl_len = '0;
  logic [AW-1:0] ctl_dst_addr = '0;
  logic          ctl_start = 1'b0;
  logic          ctl_busy, ctl_done;
  logic [31:0]   req_file_id, req_offset;
  logic [LW-1:0] req_len;
  logic          req_valid;
  logic          req_ready = 1'b1;
  logic [7:0]    resp_data = '0;
  logic          resp_valid = 1'b0;
  logic          resp_ready;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic [3:0]    wb_wmsk;
  logic          wb_we, wb_cyc;
  logic          wb_ack = 1'b0;

  always #5 clk = ~clk;

  spi_fread_dma #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .ctl_file_id(ctl_file_id), .ctl_offset(ctl_offset), .ctl_len(ctl_len),
    .ctl_dst_addr(ctl_dst_addr), .ctl_start(ctl_start),
    .ctl_busy(ctl_busy), .ctl_done(ctl_done),
    .req_file_id(req_file_id), .req_offset(req_offset), .req_len(req_len),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wmsk(wb_wmsk),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; logic [3:0] msk; } wr_t;
  typedef struct { logic [31:0] fid; logic [31:0] off; logic [LW-1:0] len; } rq_t;

  wr_t        exp_wq[$];
  rq_t        exp_rq[$];
  logic [7:0] src_q[$];   // bytes offered by the file reader, in order
  logic [7:0] pat_q[$];   // fixed payload for the next transfer, else random

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base = 0;
  int ack_delay = 1;
  int ack_wait = 0;
  bit always_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // File-reader byte source: offers the head of src_q, with random gaps
  // unless always_valid is set.
  always @(posedge clk) begin
    #1;
    if (src_q.size() > 0 && (always_valid || $urandom_range(3) != 0)) begin
      resp_valid = 1'b1;
      resp_data  = src_q[0];
    end else begin
      resp_valid = 1'b0;
      resp_data  = 8'($urandom);
    end
  end

  // Wishbone slave: acknowledges after ack_delay cycles of wb_cyc.
  always @(posedge clk) begin
    #1;
    if (wb_ack) begin
      wb_ack = 1'b0;
    end else if (wb_cyc) begin
      if (ack_wait >= ack_delay) begin
        wb_ack   = 1'b1;
        ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end else begin
      ack_wait = 0;
    end
  end

  // Monitors, sampled on the falling edge.
  logic          in_w = 1'b0;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_data;
  logic [3:0]    cap_msk;
  int            stab_err = 0;
  int            rr_err = 0;
  int            we_err = 0;

  always @(negedge clk) begin
    if (ctl_done) done_cnt++;

    if (resp_valid && resp_ready) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      else check("byte_underflow", 1, 0);
    end

    if (req_valid && req_ready) begin
      if (exp_rq.size() == 0) begin
        check("req_unexpected", 1, 0);
      end else begin
        rq_t r;
        r = exp_rq.pop_front();
        check("req_file_id", req_file_id, r.fid);
        check("req_offset", req_offset, r.off);
        check("req_len", req_len, r.len);
      end
    end

    if (wb_cyc) begin
      if (!in_w) begin
        in_w = 1'b1;
        cap_addr = wb_addr; cap_data = wb_wdata; cap_msk = wb_wmsk;
        stab_err = 0; rr_err = 0; we_err = 0;
      end else if (wb_addr !== cap_addr || wb_wdata !== cap_data || wb_wmsk !== cap_msk) begin
        stab_err++;
      end
      if (resp_ready) rr_err++;
      if (wb_we !== 1'b1) we_err++;
      if (wb_ack) begin
        if (exp_wq.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          wr_t w;
          w = exp_wq.pop_front();
          check("wb_addr", wb_addr, w.addr);
          check("wb_wdata", wb_wdata, w.data);
          check("wb_wmsk", wb_wmsk, w.msk);
        end
        check("wb_stable", stab_err, 0);
        check("resp_ready_in_write", rr_err, 0);
        check("wb_we", we_err, 0);
        in_w = 1'b0;
      end
    end else begin
      in_w = 1'b0;
    end
  end

  // Reference model: slice the payload into 4-byte groups, little-endian,
  // one write per group at consecutive (wrapping) word addresses.
  task automatic start_xfer(input logic [31:0] fid, input logic [31:0] off,
                            input logic [LW-1:0] len, input logic [AW-1:0] dst,
                            input int extras);
    int n;
    logic [7:0] b[$];
    n = int'(len) + 1;
    for (int i = 0; i < n; i++)
      b.push_back(pat_q.size() > i ? pat_q[i] : 8'($urandom));
    for (int i = 0; i < n; i += 4) begin
      wr_t w;
      w.addr = dst + AW'(i / 4);
      w.data = '0;
      w.msk  = 4'hF;
      for (int k = 0; k < 4 && i + k < n; k++) begin
        w.data = w.data | (32'(b[i+k]) << (8 * k));
        w.msk[k] = 1'b0;
      end
      exp_wq.push_back(w);
    end
    exp_rq.push_back('{fid: fid, off: off, len: len});
    foreach (b[i]) src_q.push_back(b[i]);
    for (int i = 0; i < extras; i++) src_q.push_back(8'($urandom));
    pat_q.delete();
    done_base = done_cnt;

    @(posedge clk); #1;
    ctl_file_id = fid; ctl_offset = off; ctl_len = len; ctl_dst_addr = dst;
    ctl_start = 1'b1;
    @(posedge clk); #1;
    ctl_start = 1'b0;
    ctl_file_id = $urandom; ctl_offset = $urandom;
    @(negedge clk); #1;
    check("start_to_req_valid", {req_valid, ctl_busy}, 2'b11);
  endtask

  task automatic wait_done(input int extras);
    for (int c = 0; c < 20000 && done_cnt == done_base; c++) begin
      @(negedge clk); #1;
    end
    check("done_seen", done_cnt - done_base, 1);
    repeat (4) begin @(negedge clk); #1; end
    check("done_pulse_count", done_cnt - done_base, 1);
    check("busy_after_done", ctl_busy, 0);
    check("words_outstanding", exp_wq.size(), 0);
    check("req_outstanding", exp_rq.size(), 0);
    check("extra_bytes_untouched", src_q.size(), extras);
    src_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", ctl_busy, 0);
    check("rst_done", ctl_done, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_resp_ready", resp_ready, 0);
    check("rst_wb_cyc", wb_cyc, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_wmsk", wb_wmsk, 4'hF);
    check("rst_wb_wdata", wb_wdata, 0);
    #1 rst = 1'b0;

    // 1: eight bytes 00..07, two full words
    for (int i = 0; i < 8; i++) pat_q.push_back(8'(i));
    ack_delay = 1;
    start_xfer(32'h12, 32'h100, 11'd7, 22'h40, 2);
    wait_done(2);

    // 2: five bytes, partial trailing word
    pat_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    start_xfer(32'h0BAD_F00D, 32'h0, 11'd4, 22'h1000, 2);
    wait_done(2);

    // 3: single byte; following bytes must stay unconsumed
    pat_q = '{8'h5A};
    start_xfer(32'h1, 32'h7, 11'd0, 22'h77, 3);
    wait_done(3);

    // 4: slow ack while the source keeps resp_valid high
    ack_delay = 5;
    always_valid = 1'b1;
    start_xfer($urandom, $urandom, 11'd10, 22'h2AB, 4);
    wait_done(4);
    always_valid = 1'b0;
    ack_delay = 1;

    // 5: second start during FILL is ignored
    start_xfer(32'h55, 32'h66, 11'd20, 22'h200, 0);
    for (int c = 0; c < 100 && !resp_ready; c++) begin @(negedge clk); #1; end
    check("reached_fill", resp_ready, 1);
    @(posedge clk); #1;
    ctl_dst_addr = 22'h3333; ctl_len = 11'd3; ctl_start = 1'b1;
    @(posedge clk); #1;
    ctl_start = 1'b0;
    wait_done(0);

    // 6: reset while a write is pending
    ack_delay = 1000;
    start_xfer(32'h77, 32'h88, 11'd15, 22'h500, 0);
    for (int c = 0; c < 200 && !wb_cyc; c++) begin @(negedge clk); #1; end
    check("reached_write", wb_cyc, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_wb_cyc", wb_cyc, 0);
    check("abort_req_valid", req_valid, 0);
    check("abort_busy", ctl_busy, 0);
    check("abort_done", ctl_done, 0);
    check("abort_resp_ready", resp_ready, 0);
    #1 rst = 1'b0;
    exp_wq.delete(); exp_rq.delete(); src_q.delete();
    ack_delay = 1;
    repeat (2) begin @(negedge clk); #1; end
    start_xfer(32'h99, 32'h10, 11'd6, 22'h600, 1);
    wait_done(1);

    // Randomised transfers, then the maximum length across an address wrap
    for (int t = 0; t < 10; t++) begin
      int ex;
      ex = $urandom_range(0, 3);
      ack_delay = $urandom_range(0, 3);
      start_xfer($urandom, $urandom, LW'($urandom_range(0, 40)), AW'($urandom), ex);
      wait_done(ex);
    end
    ack_delay = 0;
    start_xfer(32'hFEED, 32'h4000, 11'h7FF, 22'h3FFFFD, 2);
    wait_done(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_fread_dma.md
Name: spi_fread_dma

Overview:
Bus-mastering consumer for the SPI file-reader request/response stream. Given a file id, offset, byte length and destination word address, it does the following:
- issues one read request;
- accepts the returned byte stream and packs it little-endian into 32-bit words;
- writes each word to memory as a Wishbone master.

It lets the CPU load file chunks without polling the byte FIFO.

Parameters:
AW, 22, Wishbone word-address width.
LW, 11, length field width; the length field encodes byte count minus 1.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
ctl_file_id  in  32  file id for the transfer
ctl_offset  in  32  byte offset in the file
ctl_len  in  LW  byte count minus 1 (1..2^LW bytes)
ctl_dst_addr  in  AW  destination word address
ctl_start  in  1  one-cycle start pulse
ctl_busy  out  1  transfer in progress
ctl_done  out  1  one-cycle pulse at completion
req_file_id  out  32  request file id
req_offset  out  32  request offset
req_len  out  LW  request length (count-1)
req_valid  out  1  request valid
req_ready  in  1  request accepted
resp_data  in  8  returned byte
resp_valid  in  1  byte available
resp_ready  out  1  byte consumed this cycle
wb_addr  out  AW  word address
wb_wdata  out  32  write data
wb_wmsk  out  4  byte-lane mask; bit set = lane NOT written
wb_we  out  1  always 1 while wb_cyc=1
wb_cyc  out  1  cycle request
wb_ack  in  1  cycle acknowledge

Behaviour:
- Reset values: ctl_busy=0, ctl_done=0, req_valid=0, resp_ready=0, wb_cyc=0, wb_we=0, wb_wmsk=4'hF, wb_wdata=0. rst mid-transfer aborts everything immediately to IDLE with these values.
- States: IDLE, REQ, FILL, WRITE, DONE.
- IDLE:
  - ctl_start=1 latches all ctl_* inputs.
  - Loads remaining byte count = ctl_len+1 (LW+1 bits) and clears the lane index.
  - Next cycle: REQ.
- ctl_start in any non-IDLE state is ignored; latched values are not altered.
- REQ:
  - req_valid=1; req_* are driven from the latched values.
  - On req_valid & req_ready, go to FILL next cycle with req_valid=0.
- FILL:
  - resp_ready = resp_valid, i.e. one byte is accepted per cycle in which resp_valid=1.
  - Each byte goes into lane = lane index (bits [8*i+7:8*i]). The lane index increments and the remaining count decrements.
  - After the byte completing lane 3, or the last byte: go to WRITE next cycle, with resp_ready=0 from that cycle on.
- WRITE:
  - wb_cyc=1 and wb_we=1; wb_addr = current dst address.
  - wb_wmsk has bits set for lanes not filled in this word (e.g. 2 bytes -> 4'b1100).
  - Signals hold stable until wb_ack. On ack, wb_cyc drops in the next cycle, dst address +1 (wraps mod 2^AW), and the lane index clears.
  - Then: DONE if remaining=0, otherwise FILL.
- DONE: ctl_done=1 for exactly one cycle, then IDLE. ctl_busy=1 in every state except IDLE.
- Transfer length is 1..2^LW bytes; an 11-bit ctl_len of 0x7FF transfers 2048 bytes (512 words).
- Bytes beyond the requested length are never consumed; resp_ready=0 outside FILL.
- Latency:
  - start -> req_valid: 1 cycle.
  - final byte -> wb_cyc: 1 cycle.
  - wb_ack -> ctl_done: 1 cycle for the last word.
- Packing data register cleared at each word start; masked lanes drive 0.

Test Plan:
1. Start with file_id=0x12, offset=0x100, len=7, dst=0x40; req_ready=1 immediately; stream bytes 00..07 back-to-back; wb_ack after 1 cycle.
   -> req_* show 0x12/0x100/7.
   -> Writes 0x03020100 @0x40 and 0x07060504 @0x41, both wmsk=0.
   -> One ctl_done pulse.
2. len=4 (5 bytes AA..EE).
   -> Writes 0xDDCCBBAA wmsk=0 @dst, then 0x000000EE wmsk=4'b1110 @dst+1.
3. len=0, single byte 0x5A.
   -> One write 0x0000005A, wmsk=4'b1110; resp_ready never high again.
4. wb_ack delayed 5 cycles; resp_valid held high throughout.
   -> wb_addr/wdata/wmsk stable until ack; resp_ready=0 during WRITE; no byte lost.
5. ctl_start pulsed again during FILL with a different dst.
   -> Ignored; all writes go to the original dst.
6. rst asserted during WRITE with wb_cyc=1.
   -> Next cycle wb_cyc=0, req_valid=0, ctl_busy=0, ctl_done=0; a new start afterwards runs normally.
